// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller between EX/MEM and MEM/WB.
// Issues dcache load/store requests, stalls the pipeline while a request is
// outstanding, parks completed data while the pipeline is frozen, and owns
// the LL/SC link register with snoop-driven invalidation.
module mem_access_unit #(
    parameter int unsigned LINK_IGNORE_BITS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_dREN,
    input  logic        ex_dWEN,
    input  logic        ex_ll,
    input  logic        ex_sc,
    input  logic        ex_WEN,
    input  logic [4:0]  ex_dest,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        advance,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_WEN,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        link_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req_ren;
    logic        r_req_wen;
    logic        r_req_ll;
    logic        r_req_sc;
    logic        r_req_WEN;
    logic [4:0]  r_req_dest;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_data;
    logic [31:0] r_hold_data;
    logic        r_link_valid;
    logic [31:0] r_link_addr;

    // Word-granular address compare used by SC, local stores and snoops.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return (a >> LINK_IGNORE_BITS) == (b >> LINK_IGNORE_BITS);
    endfunction

    logic        w_idle;
    logic        w_mem_op;
    logic        w_sc_ok;
    logic        w_sc_fail;
    logic        w_issue;
    logic        w_req_active;
    logic        w_req_ren;
    logic        w_req_wen;
    logic        w_req_ll;
    logic        w_req_sc;
    logic        w_req_WEN;
    logic [4:0]  w_req_dest;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_data;
    logic [31:0] w_sw_wb;
    logic [31:0] w_result;
    logic        w_store_done;
    logic        w_ll_done;
    logic        w_link_clr;

    // Request attributes come straight from EX/MEM in IDLE, from the latched copy otherwise.
    assign w_idle       = (r_state == IDLE);
    assign w_mem_op     = ex_valid & (ex_dREN | ex_dWEN);
    assign w_sc_ok      = r_link_valid & word_match(r_link_addr, ex_addr);
    assign w_sc_fail    = ex_sc & ex_dWEN & ~w_sc_ok;
    assign w_issue      = w_idle & ~flush & w_mem_op & ~w_sc_fail;
    assign w_req_active = w_issue | (r_state == ACCESS) | (r_state == DRAIN);

    assign w_req_ren  = w_idle ? ex_dREN       : r_req_ren;
    assign w_req_wen  = w_idle ? ex_dWEN       : r_req_wen;
    assign w_req_ll   = w_idle ? ex_ll         : r_req_ll;
    assign w_req_sc   = w_idle ? ex_sc         : r_req_sc;
    assign w_req_dest = w_idle ? ex_dest       : r_req_dest;
    assign w_req_addr = w_idle ? ex_addr       : r_req_addr;
    assign w_req_data = w_idle ? ex_store_data : r_req_data;
    // A plain store never writes the register file; SC writes its success flag.
    assign w_req_WEN  = w_idle ? (ex_WEN & ~(ex_dWEN & ~ex_sc)) : r_req_WEN;
    assign w_sw_wb    = w_idle ? ex_alu_result : r_req_addr;

    // Writeback value of the current request at completion.
    assign w_result = w_req_ren ? dmemload : (w_req_sc ? 32'd1 : w_sw_wb);

    // Link-register events; a drained or flush-discarded LL never sets the link.
    assign w_store_done = w_req_active & dhit & w_req_wen;
    assign w_ll_done    = w_req_active & dhit & w_req_ren & w_req_ll & ~flush
                        & (r_state != DRAIN);
    assign w_link_clr   = (r_link_valid & w_store_done & word_match(w_req_addr, r_link_addr))
                        | (r_link_valid & ccinv & word_match(ccsnoopaddr, r_link_addr))
                        | (w_ll_done & ccinv & word_match(ccsnoopaddr, w_req_addr));

    assign link_valid = r_link_valid;

    // State machine, request latch and hold buffer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_req_ren   <= 1'b0;
            r_req_wen   <= 1'b0;
            r_req_ll    <= 1'b0;
            r_req_sc    <= 1'b0;
            r_req_WEN   <= 1'b0;
            r_req_dest  <= 5'd0;
            r_req_addr  <= 32'd0;
            r_req_data  <= 32'd0;
            r_hold_data <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_req_ren  <= ex_dREN;
                        r_req_wen  <= ex_dWEN;
                        r_req_ll   <= ex_ll;
                        r_req_sc   <= ex_sc;
                        r_req_WEN  <= w_req_WEN;
                        r_req_dest <= ex_dest;
                        r_req_addr <= ex_addr;
                        r_req_data <= ex_store_data;
                        if (dhit && !advance) begin
                            r_hold_data <= w_result;
                            r_state     <= HOLD;
                        end else if (!dhit) begin
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        if (flush || advance) begin
                            r_state <= IDLE;
                        end else begin
                            r_hold_data <= w_result;
                            r_state     <= HOLD;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (advance || flush) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (dhit) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // LL/SC link register; any clearing event beats a same-cycle set.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= 32'd0;
        end else if (w_link_clr) begin
            r_link_valid <= 1'b0;
        end else if (w_ll_done) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= w_req_addr;
        end
    end

    // Dcache request, stall and writeback fields for the current state.
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = 32'd0;
        dmemstore = 32'd0;
        mem_stall = 1'b0;
        wb_valid  = 1'b0;
        wb_WEN    = 1'b0;
        wb_dest   = 5'd0;
        wb_data   = 32'd0;
        case (r_state)
            IDLE: begin
                if (!flush) begin
                    if (!w_mem_op) begin
                        wb_valid = ex_valid;
                        wb_WEN   = ex_WEN;
                        wb_dest  = ex_dest;
                        wb_data  = ex_alu_result;
                    end else if (w_sc_fail) begin
                        wb_valid = 1'b1;
                        wb_WEN   = ex_WEN;
                        wb_dest  = ex_dest;
                        wb_data  = 32'd0;
                    end else begin
                        dmemREN   = ex_dREN;
                        dmemWEN   = ex_dWEN;
                        dmemaddr  = ex_addr;
                        dmemstore = ex_store_data;
                        mem_stall = ~dhit;
                        wb_valid  = dhit;
                        wb_WEN    = w_req_WEN;
                        wb_dest   = ex_dest;
                        wb_data   = w_result;
                    end
                end
            end
            ACCESS: begin
                dmemREN   = r_req_ren;
                dmemWEN   = r_req_wen;
                dmemaddr  = r_req_addr;
                dmemstore = r_req_data;
                mem_stall = ~dhit;
                wb_valid  = dhit & ~flush;
                wb_WEN    = r_req_WEN;
                wb_dest   = r_req_dest;
                wb_data   = w_result;
            end
            HOLD: begin
                wb_valid = ~flush;
                wb_WEN   = r_req_WEN;
                wb_dest  = r_req_dest;
                wb_data  = r_hold_data;
            end
            DRAIN: begin
                dmemREN   = r_req_ren;
                dmemWEN   = r_req_wen;
                dmemaddr  = r_req_addr;
                dmemstore = r_req_data;
                mem_stall = 1'b1;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: reset check, table of single-cycle IDLE
// vectors, hand-written multi-cycle sequences, then randomized traffic
// against a transaction-level reference model.
module tb_mem_access_unit;

    // 8-byte link granule so that 0x100 and 0x104 share a link word.
    localparam int unsigned LIB = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc, ex_WEN;
    logic [4:0]  ex_dest;
    logic [31:0] ex_addr, ex_alu_result, ex_store_data;
    logic        advance, flush, dhit, ccinv;
    logic [31:0] dmemload, ccsnoopaddr;
    logic        dmemREN, dmemWEN, mem_stall, wb_valid, wb_WEN, link_valid;
    logic [31:0] dmemaddr, dmemstore, wb_data;
    logic [4:0]  wb_dest;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(.LINK_IGNORE_BITS(LIB)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
        .ex_ll(ex_ll), .ex_sc(ex_sc), .ex_WEN(ex_WEN), .ex_dest(ex_dest),
        .ex_addr(ex_addr), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .advance(advance), .flush(flush),
        .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_WEN(wb_WEN), .wb_dest(wb_dest),
        .wb_data(wb_data), .link_valid(link_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_ll = 0; ex_sc = 0; ex_WEN = 0;
        ex_dest = 0; ex_addr = 0; ex_alu_result = 0; ex_store_data = 0;
        advance = 1; flush = 0; dhit = 0; dmemload = 0; ccinv = 0; ccsnoopaddr = 0;
    endtask

    // kind: 0 ALU, 1 LW, 2 LL, 3 SW, 4 SC
    task automatic op(input int kind, input logic [4:0] dest, input logic [31:0] addr,
                      input logic [31:0] sdata);
        ex_valid = 1;
        ex_dREN = (kind == 1 || kind == 2);
        ex_ll   = (kind == 2);
        ex_dWEN = (kind == 3 || kind == 4);
        ex_sc   = (kind == 4);
        ex_WEN  = (kind != 3);
        ex_dest = dest; ex_addr = addr; ex_alu_result = addr; ex_store_data = sdata;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic valid, ren, wen, sc, rfw, flush, dhit;
        logic [4:0]  dest;
        logic [31:0] addr, dload;
        logic e_ren, e_wen, e_stall, e_wbv, e_wbwen;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mkv(input logic valid, ren, wen, sc, rfw, fl, dh,
                                 input logic [4:0] dest, input logic [31:0] addr, dload,
                                 input logic e_ren, e_wen, e_stall, e_wbv, e_wbwen,
                                 input logic [31:0] e_data);
        vec_t v;
        v.valid = valid; v.ren = ren; v.wen = wen; v.sc = sc; v.rfw = rfw;
        v.flush = fl; v.dhit = dh; v.dest = dest; v.addr = addr; v.dload = dload;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_stall = e_stall; v.e_wbv = e_wbv;
        v.e_wbwen = e_wbwen; v.e_data = e_data;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic ren, wen, ll, sc, rfw;
        logic [4:0]  dest;
        logic [31:0] addr, sdata;
    } txn_t;

    bit          m_busy, m_drop, m_held, m_lv;
    txn_t        m_t;
    logic [31:0] m_hold, m_la;

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return (a >> LIB) == (b >> LIB);
    endfunction

    function automatic logic [31:0] txn_result(input txn_t t, input logic [31:0] dl);
        if (t.ren) return dl;
        if (t.sc)  return 32'd1;
        return t.addr;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_drop = 0; m_held = 0; m_lv = 0; m_hold = 0; m_la = 0;
        m_t = '{default: '0};
    endtask

    // One cycle of the model at the sampling point, comparing against the DUT.
    task automatic model_step();
        txn_t cur;
        bit req_on, e_stall, e_wbv, e_wbwen, e_lv, old_drop, clr, ll_done;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        req_on = 0; e_stall = 0; e_wbv = 0; e_wbwen = 0; e_dest = 0; e_data = 0;
        cur = m_t; e_lv = m_lv; old_drop = m_drop;
        if (m_busy) begin
            req_on  = 1;
            e_stall = m_drop ? 1'b1 : !dhit;
            e_wbv   = !m_drop && dhit && !flush;
            e_wbwen = cur.rfw; e_dest = cur.dest; e_data = txn_result(cur, dmemload);
            if (dhit) begin
                m_busy = 0;
                if (!m_drop && !flush && !advance) begin m_held = 1; m_hold = e_data; end
                m_drop = 0;
            end else if (flush) begin
                m_drop = 1;
            end
        end else if (m_held) begin
            e_wbv = !flush; e_wbwen = m_t.rfw; e_dest = m_t.dest; e_data = m_hold;
            if (advance || flush) m_held = 0;
        end else if (!flush) begin
            if (!(ex_valid && (ex_dREN || ex_dWEN))) begin
                e_wbv = ex_valid; e_wbwen = ex_WEN; e_dest = ex_dest; e_data = ex_alu_result;
            end else if (ex_sc && ex_dWEN && !(m_lv && same_word(m_la, ex_addr))) begin
                e_wbv = 1; e_wbwen = ex_WEN; e_dest = ex_dest; e_data = 0;
            end else begin
                cur.ren = ex_dREN; cur.wen = ex_dWEN; cur.ll = ex_ll; cur.sc = ex_sc;
                cur.rfw = ex_WEN && !(ex_dWEN && !ex_sc);
                cur.dest = ex_dest; cur.addr = ex_addr; cur.sdata = ex_store_data;
                m_t = cur; req_on = 1;
                e_stall = !dhit; e_wbv = dhit;
                e_wbwen = cur.rfw; e_dest = cur.dest; e_data = txn_result(cur, dmemload);
                if (dhit && !advance) begin m_held = 1; m_hold = e_data; end
                else if (!dhit) m_busy = 1;
            end
        end
        // link register
        ll_done = req_on && dhit && cur.ren && cur.ll && !old_drop && !flush;
        clr = 0;
        if (m_lv && req_on && dhit && cur.wen && same_word(cur.addr, m_la)) clr = 1;
        if (m_lv && ccinv && same_word(ccsnoopaddr, m_la)) clr = 1;
        if (ll_done && ccinv && same_word(ccsnoopaddr, cur.addr)) clr = 1;
        if (clr) m_lv = 0;
        else if (ll_done) begin m_lv = 1; m_la = cur.addr; end

        chk("rnd.link_valid", 32'(link_valid), 32'(e_lv));
        chk("rnd.dmemREN", 32'(dmemREN), 32'(req_on && cur.ren));
        chk("rnd.dmemWEN", 32'(dmemWEN), 32'(req_on && cur.wen));
        chk("rnd.mem_stall", 32'(mem_stall), 32'(e_stall));
        chk("rnd.wb_valid", 32'(wb_valid), 32'(e_wbv));
        if (req_on) chk("rnd.dmemaddr", dmemaddr, cur.addr);
        if (req_on && cur.wen) chk("rnd.dmemstore", dmemstore, cur.sdata);
        if (e_wbv) begin
            chk("rnd.wb_WEN", 32'(wb_WEN), 32'(e_wbwen));
            chk("rnd.wb_dest", 32'(wb_dest), 32'(e_dest));
            if (e_wbwen) chk("rnd.wb_data", wb_data, e_data);
        end
    endtask

    initial begin
        vec_t vecs[8];
        logic [31:0] pool[4];
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108; pool[3] = 32'h200;

        // ---------- reset ----------
        idle_in();
        nRST = 0;
        #12;
        chk("rst.dmemREN", 32'(dmemREN), 0);
        chk("rst.dmemWEN", 32'(dmemWEN), 0);
        chk("rst.mem_stall", 32'(mem_stall), 0);
        chk("rst.wb_valid", 32'(wb_valid), 0);
        chk("rst.link_valid", 32'(link_valid), 0);
        @(negedge CLK); nRST = 1;

        // ---------- table vectors (all stay in IDLE) ----------
        vecs[0] = mkv(1,0,0,0,1,0,0, 5'd3, 32'h1234, 0,          0,0,0,1,1, 32'h1234);
        vecs[1] = mkv(0,0,0,0,0,0,0, 5'd4, 32'h5,    0,          0,0,0,0,0, 0);
        vecs[2] = mkv(1,1,0,0,1,1,1, 5'd5, 32'h40,   32'h99,     0,0,0,0,0, 0);
        vecs[3] = mkv(1,1,0,0,1,0,1, 5'd7, 32'h40,   32'hCAFEF00D, 1,0,0,1,1, 32'hCAFEF00D);
        vecs[4] = mkv(1,0,1,0,0,0,1, 5'd0, 32'h80,   32'h1,      0,1,0,1,0, 0);
        vecs[5] = mkv(1,0,1,1,1,0,1, 5'd2, 32'h100,  0,          0,0,0,1,1, 0);
        vecs[6] = mkv(1,0,0,0,0,0,0, 5'd6, 32'h77,   0,          0,0,0,1,0, 0);
        vecs[7] = mkv(1,0,1,0,1,0,1, 5'd9, 32'h84,   0,          0,1,0,1,0, 0);
        foreach (vecs[i]) begin
            step();
            idle_in();
            ex_valid = vecs[i].valid; ex_dREN = vecs[i].ren; ex_dWEN = vecs[i].wen;
            ex_sc = vecs[i].sc; ex_WEN = vecs[i].rfw; ex_dest = vecs[i].dest;
            ex_addr = vecs[i].addr; ex_alu_result = vecs[i].addr;
            ex_store_data = ~vecs[i].addr; flush = vecs[i].flush; dhit = vecs[i].dhit;
            dmemload = vecs[i].dload;
            @(negedge CLK);
            chk($sformatf("vec%0d.ren", i), 32'(dmemREN), 32'(vecs[i].e_ren));
            chk($sformatf("vec%0d.wen", i), 32'(dmemWEN), 32'(vecs[i].e_wen));
            chk($sformatf("vec%0d.stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d.wbv", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
            if (vecs[i].e_ren || vecs[i].e_wen)
                chk($sformatf("vec%0d.addr", i), dmemaddr, vecs[i].addr);
            if (vecs[i].e_wbv) begin
                chk($sformatf("vec%0d.wbwen", i), 32'(wb_WEN), 32'(vecs[i].e_wbwen));
                chk($sformatf("vec%0d.dest", i), 32'(wb_dest), 32'(vecs[i].dest));
            end
            if (vecs[i].e_wbwen)
                chk($sformatf("vec%0d.data", i), wb_data, vecs[i].e_data);
        end

        // ---------- LW, dhit three cycles after the request ----------
        step(); idle_in(); op(1, 5'd5, 32'h200, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("lw3.stall%0d", c), 32'(mem_stall), 1);
            chk($sformatf("lw3.ren%0d", c), 32'(dmemREN), 1);
            step();
        end
        dhit = 1; dmemload = 32'hDEADBEEF;
        @(negedge CLK);
        chk("lw3.stall_hit", 32'(mem_stall), 0);
        chk("lw3.wbv", 32'(wb_valid), 1);
        chk("lw3.data", wb_data, 32'hDEADBEEF);
        chk("lw3.dest", 32'(wb_dest), 5);
        chk("lw3.wen", 32'(wb_WEN), 1);
        step(); idle_in();
        @(negedge CLK);
        chk("lw3.idle_ren", 32'(dmemREN), 0);
        chk("lw3.idle_stall", 32'(mem_stall), 0);

        // ---------- LW hit while pipeline frozen -> HOLD ----------
        step(); idle_in(); op(1, 5'd11, 32'h210, 0);
        dhit = 1; dmemload = 32'hDEADBEEF; advance = 0;
        @(negedge CLK);
        chk("hold.hit_wbv", 32'(wb_valid), 1);
        chk("hold.hit_data", wb_data, 32'hDEADBEEF);
        for (int c = 0; c < 2; c++) begin
            step(); dhit = 0; dmemload = 32'h12345678;
            @(negedge CLK);
            chk($sformatf("hold.ren%0d", c), 32'(dmemREN), 0);
            chk($sformatf("hold.stall%0d", c), 32'(mem_stall), 0);
            chk($sformatf("hold.data%0d", c), wb_data, 32'hDEADBEEF);
            chk($sformatf("hold.dest%0d", c), 32'(wb_dest), 11);
        end
        step(); advance = 1;
        @(negedge CLK);
        chk("hold.adv_data", wb_data, 32'hDEADBEEF);
        chk("hold.adv_wbv", 32'(wb_valid), 1);
        step(); idle_in();
        @(negedge CLK);
        chk("hold.idle_wbv", 32'(wb_valid), 0);

        // ---------- LL 0x100 then SC 0x104 succeeds ----------
        step(); idle_in(); op(2, 5'd8, 32'h100, 0); dhit = 1; dmemload = 32'h77;
        step(); idle_in();
        @(negedge CLK);
        chk("llsc.link_set", 32'(link_valid), 1);
        step(); op(4, 5'd9, 32'h104, 32'h5);
        @(negedge CLK);
        chk("llsc.wen", 32'(dmemWEN), 1);
        chk("llsc.addr", dmemaddr, 32'h104);
        chk("llsc.store", dmemstore, 32'h5);
        step(); dhit = 1;
        @(negedge CLK);
        chk("llsc.wen_hit", 32'(dmemWEN), 1);
        chk("llsc.wbv", 32'(wb_valid), 1);
        chk("llsc.data", wb_data, 1);
        step(); idle_in();
        @(negedge CLK);
        chk("llsc.link_clr", 32'(link_valid), 0);

        // ---------- LL, snoop invalidate, SC fails ----------
        step(); op(2, 5'd8, 32'h100, 0); dhit = 1;
        step(); idle_in(); ccinv = 1; ccsnoopaddr = 32'h100;
        @(negedge CLK);
        chk("inv.link_before", 32'(link_valid), 1);
        step(); idle_in();
        @(negedge CLK);
        chk("inv.link_after", 32'(link_valid), 0);
        step(); op(4, 5'd10, 32'h100, 32'h5);
        @(negedge CLK);
        chk("inv.sc_wen", 32'(dmemWEN), 0);
        chk("inv.sc_stall", 32'(mem_stall), 0);
        chk("inv.sc_wbv", 32'(wb_valid), 1);
        chk("inv.sc_data", wb_data, 0);

        // ---------- SW flushed mid-flight drains to dhit ----------
        step(); idle_in(); op(3, 5'd0, 32'h300, 32'hABCD);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) flush = 1;
            if (c == 2) begin flush = 0; ex_valid = 0; end
            if (c == 4) dhit = 1;
            @(negedge CLK);
            chk($sformatf("drain.wen%0d", c), 32'(dmemWEN), 1);
            chk($sformatf("drain.addr%0d", c), dmemaddr, 32'h300);
            chk($sformatf("drain.store%0d", c), dmemstore, 32'hABCD);
            if (c > 0) chk($sformatf("drain.wbv%0d", c), 32'(wb_valid), 0);
            if (c > 0 && c < 4) chk($sformatf("drain.stall%0d", c), 32'(mem_stall), 1);
            step();
        end
        idle_in();
        @(negedge CLK);
        chk("drain.done_wen", 32'(dmemWEN), 0);
        chk("drain.done_stall", 32'(mem_stall), 0);

        // ---------- reset during ACCESS ----------
        step(); op(2, 5'd8, 32'h100, 0); dhit = 1;
        step(); idle_in(); op(1, 5'd3, 32'h400, 0);
        step(); idle_in();
        @(negedge CLK);
        chk("rstmid.pre_ren", 32'(dmemREN), 1);
        chk("rstmid.pre_link", 32'(link_valid), 1);
        step(); #2; nRST = 0; #1;
        chk("rstmid.ren", 32'(dmemREN), 0);
        chk("rstmid.stall", 32'(mem_stall), 0);
        chk("rstmid.link", 32'(link_valid), 0);
        @(negedge CLK); nRST = 1;

        // ---------- randomized traffic vs reference model ----------
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            int k;
            step();
            idle_in();
            k = int'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 85) op(k, 5'($urandom_range(0, 31)),
                                               pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3)),
                                               $urandom);
            else begin ex_dREN = 1'($urandom); ex_dest = 5'($urandom); end
            if (k == 0) ex_alu_result = $urandom;
            advance     = ($urandom_range(0, 99) < 70);
            flush       = ($urandom_range(0, 99) < 10);
            dhit        = ($urandom_range(0, 99) < 40);
            dmemload    = $urandom;
            ccinv       = ($urandom_range(0, 99) < 15);
            ccsnoopaddr = pool[$urandom_range(0, 3)];
            @(negedge CLK);
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller that sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues load/store requests to the dcache and waits on dhit, asserting mem_stall while a request is outstanding.
- Holds the returned load data when the pipeline cannot advance, and produces the writeback fields that the MEM/WB register captures.
- Owns the LL/SC link register, including snoop-driven link invalidation.

Parameters:
- LINK_IGNORE_BITS, 2, low address bits ignored when comparing against the link address (word granularity).

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX/MEM register holds a live instruction.
- ex_dREN  input  1  instruction is a load (LW/LL).
- ex_dWEN  input  1  instruction is a store (SW/SC).
- ex_ll  input  1  load-linked.
- ex_sc  input  1  store-conditional.
- ex_WEN  input  1  instruction writes the register file.
- ex_dest  input  5  destination register.
- ex_addr  input  32  effective address (ALU result).
- ex_alu_result  input  32  ALU result, for non-memory ops.
- ex_store_data  input  32  store data (rdat2).
- advance  input  1  MEM/WB register enable this cycle.
- flush  input  1  squash the instruction in MEM.
- dhit  input  1  dcache completes the current request.
- dmemload  input  32  load data; valid when dhit=1.
- ccinv  input  1  coherence invalidate from another core.
- ccsnoopaddr  input  32  invalidated address.
- dmemREN  output  1  read request.
- dmemWEN  output  1  write request.
- dmemaddr  output  32  request address.
- dmemstore  output  32  write data.
- mem_stall  output  1  MEM stage not complete; hazard unit freezes upstream.
- wb_valid  output  1  writeback fields valid.
- wb_WEN  output  1  writeback enable.
- wb_dest  output  5  writeback register.
- wb_data  output  32  writeback value.
- link_valid  output  1  debug view of the link register.

Behaviour:
- Definitions:
  - mem_op = ex_valid & (ex_dREN | ex_dWEN).
  - sc_ok = link_valid & (link_addr[31:LINK_IGNORE_BITS] == ex_addr[31:LINK_IGNORE_BITS]).
  - sc_fail = ex_sc & ex_dWEN & ~sc_ok.
- Registers: state, req_addr, req_data, req_ren, req_wen, req_ll, req_sc, req_dest, req_WEN, hold_data, link_valid, link_addr.
- Reset: state=IDLE; all registers zero. Outputs are zero except where the combinational rules below drive them from the ex_* inputs.
- FSM states: IDLE, ACCESS, HOLD, DRAIN.
- IDLE, with flush=1: no request; wb_valid=0; mem_stall=0.
- IDLE, non-memory op:
  - wb_valid=ex_valid, wb_WEN=ex_WEN, wb_dest=ex_dest, wb_data=ex_alu_result.
  - Zero latency; mem_stall=0.
- IDLE, sc_fail:
  - No dcache request.
  - wb_data=0, wb_WEN=ex_WEN.
  - Completes in 0 wait cycles.
- IDLE, mem_op (not sc_fail):
  - Request is driven combinationally from the ex_* inputs in the same cycle.
  - Request attributes are latched into the req_* registers.
  - dhit & advance: complete; stay IDLE.
  - dhit & ~advance: hold_data <= dmemload (SC: hold_data <= 1); go to HOLD.
  - ~dhit: mem_stall=1; go to ACCESS.
- ACCESS:
  - Request is driven from the req_* registers; mem_stall=1 until dhit.
  - dhit & advance: go to IDLE.
  - dhit & ~advance: latch hold_data; go to HOLD.
  - flush (no dhit): go to DRAIN.
  - flush coincident with dhit: the completion is discarded (wb_valid=0) and the FSM goes to IDLE.
- HOLD:
  - No request; mem_stall=0.
  - wb_data=hold_data, wb_dest=req_dest, wb_WEN=req_WEN.
  - advance: go to IDLE.
  - flush: go to IDLE, wb_valid=0.
- DRAIN:
  - Request is kept asserted until dhit; an in-flight dcache transaction is never withdrawn.
  - wb_valid=0; mem_stall=1.
  - dhit: go to IDLE.
  - A drained store still writes memory.
  - A drained LL does not set the link.
- Completion wb_data:
  - Load: dmemload, or hold_data in HOLD.
  - SW: ex_alu_result / req_addr; wb_WEN=0.
  - Successful SC: 1.
- Link register (evaluated each cycle, in priority order):
  1. Clear if a local store completes (dhit & write) to a matching word, including a successful SC.
  2. Clear if ccinv and ccsnoopaddr matches link_addr.
  3. Set (link_valid=1, link_addr=addr) if a non-drained LL completes.
  - Invalidation wins over a same-cycle set: an LL completing while a matching ccinv arrives leaves link_valid=0.
- Reset mid-ACCESS: returns to IDLE immediately and drops the request. The dcache is reset by the same nRST.

Test Plan:
1. LW with dhit at request cycle +3, advance=1 → mem_stall=1 for 3 cycles; at dhit, wb_data=dmemload=0xDEADBEEF, wb_dest=ex_dest, wb_WEN=1; state returns to IDLE.
2. LW with dhit while advance=0 → HOLD; dmemREN deasserts next cycle; wb_data stays 0xDEADBEEF until advance=1, then IDLE.
3. LL to 0x100, then SC to 0x104 with data 0x5 → SC issues dmemWEN, dmemaddr=0x104; wb_data=1; link_valid=0 afterwards.
4. LL to 0x100, then ccinv with ccsnoopaddr=0x100, then SC to 0x100 → no dmemWEN; wb_data=0 with zero stall.
5. SW outstanding, flush asserted on cycle 1, dhit on cycle 4 → dmemWEN held through cycle 4; wb_valid=0; mem_stall drops after dhit.
6. Reset asserted mid-ACCESS → dmemREN=0, mem_stall=0, link_valid=0 asynchronously.
